// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and scheduler state encoding for the uart tx scheduler
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int MAX_NREQ = 8;
  localparam int GID_W = 3;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} sched_state_t;
endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester streams (valid/data/last/ready) and transmitter link (data/load/empty_it); slave = scheduler, master = producers+tx
interface uart_tx_sched_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] req_ready;
  logic [7:0] tx_data;
  logic tx_load;
  logic tx_empty_it;
  modport master (output req_valid, req_data, req_last, tx_empty_it, input req_ready, tx_data, tx_load);
  modport slave (input req_valid, req_data, req_last, tx_empty_it, output req_ready, tx_data, tx_load);
endinterface

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick; valid/ptr in, any/winner out (first valid at or after ptr, wrapping)
module uart_rr_arbiter import uart_pkg::*; #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [GID_W-1:0] ptr,
  output logic             any,
  output logic [GID_W-1:0] winner
);
  logic [NREQ-1:0] rot;
  logic [GID_W-1:0] off;
  logic [GID_W:0] sum;
  assign rot = NREQ'({valid, valid} >> ptr);
  always_comb begin
    off = '0;
    for (int j = NREQ - 1; j >= 0; j--) if (rot[j]) off = GID_W'(j);
  end
  assign any = |valid;
  assign sum = {1'b0, ptr} + {1'b0, off};
  assign winner = (sum >= (GID_W + 1)'(NREQ)) ? GID_W'(sum - (GID_W + 1)'(NREQ)) : sum[GID_W-1:0];
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin share of one uart tx among NREQ byte streams; clk/rst/cfg_enable in, io bus, grant_active/grant_id/err_timeout out
module uart_tx_sched import uart_pkg::*; #(
  parameter int NREQ = 4,
  parameter int MAX_BURST = 16,
  parameter int IDLE_TO = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_enable,
  uart_tx_sched_if.slave   io,
  output logic             grant_active,
  output logic [GID_W-1:0] grant_id,
  output logic             err_timeout
);
  sched_state_t state, state_n;
  logic [GID_W-1:0] rr_ptr, rr_n, gid_n, winner, gid_inc;
  logic credit, credit_n, any, act, hs, to, rel, start, sel_valid, sel_last, tx_load_n, err_n;
  logic [7:0] burst_cnt, burst_n;
  logic [9:0] idle_cnt, idle_n;
  logic [UART_BYTE_W-1:0] sel_byte, tx_data_n;
  logic [NREQ-1:0] own;
  uart_rr_arbiter #(.NREQ(NREQ)) arb (.valid(io.req_valid), .ptr(rr_ptr), .any(any), .winner(winner));
  assign own = NREQ'(1) << grant_id;
  assign sel_valid = |(io.req_valid & own);
  assign sel_last = |(io.req_last & own);
  assign sel_byte = UART_BYTE_W'(io.req_data >> {grant_id, 3'b000});
  assign act = (state == GRANT) && cfg_enable;
  assign io.req_ready = (act && credit) ? own : '0;
  assign hs = act && credit && sel_valid;
  assign to = act && !sel_valid && (idle_cnt == 10'(IDLE_TO - 1));
  assign rel = (hs && (sel_last || (burst_cnt + 8'd1 == 8'(MAX_BURST)))) || to;
  assign start = (state == IDLE) && cfg_enable && any;
  assign gid_inc = (grant_id == GID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  assign grant_active = (state == GRANT);
  always_comb begin
    state_n = start ? GRANT : (state == GRANT && (!cfg_enable || rel)) ? IDLE : state;
    gid_n = start ? winner : grant_id;
    rr_n = rel ? gid_inc : rr_ptr;
    credit_n = hs ? 1'b0 : io.tx_empty_it ? 1'b1 : credit;
    burst_n = start ? 8'd0 : hs ? burst_cnt + 8'd1 : burst_cnt;
    idle_n = (start || hs) ? 10'd0 : (act && !sel_valid) ? idle_cnt + 10'd1 : idle_cnt;
    tx_load_n = hs;
    tx_data_n = hs ? sel_byte : io.tx_data;
    err_n = to;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      credit <= 1'b1;
      burst_cnt <= '0;
      idle_cnt <= '0;
      grant_id <= '0;
      io.tx_load <= 1'b0;
      io.tx_data <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      credit <= credit_n;
      burst_cnt <= burst_n;
      idle_cnt <= idle_n;
      grant_id <= gid_n;
      io.tx_load <= tx_load_n;
      io.tx_data <= tx_data_n;
      err_timeout <= err_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst, cfg_enable, grant_active, err_timeout;
  logic [2:0] grant_id;
  logic [8:0] pk [4][32];
  int hd [4];
  int tl [4];
  int checks = 0;
  int failures = 0;
  int ecd = 0;
  int n;
  logic tb_credit = 1'b1;
  uart_tx_sched_if #(.NREQ(4)) ifc ();
  uart_tx_sched #(.NREQ(4), .MAX_BURST(16), .IDLE_TO(64)) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .io(ifc),
    .grant_active(grant_active), .grant_id(grant_id), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(input int r, input logic [7:0] d, input logic l);
    pk[r][tl[r]] = {l, d};
    tl[r]++;
  endtask
  task automatic drive();
    logic [3:0] v, l;
    logic [31:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < 4; i++)
      if (hd[i] < tl[i]) begin
        v[i] = 1'b1;
        l[i] = pk[i][hd[i]][8];
        d[8*i +: 8] = pk[i][hd[i]][7:0];
      end
    ifc.req_valid = v;
    ifc.req_last = l;
    ifc.req_data = d;
  endtask
  task automatic tick();
    logic [3:0] hs;
    logic em;
    @(negedge clk);
    hs = ifc.req_valid & ifc.req_ready;
    em = ifc.tx_empty_it;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) hd[i]++;
    if (ifc.tx_load === 1'b1) begin
      chk("credit_gate", {31'd0, tb_credit}, 1);
      tb_credit = 1'b0;
    end
    if (em) tb_credit = 1'b1;
    ifc.tx_empty_it = 1'b0;
    if (ecd > 0) begin
      ecd--;
      if (ecd == 0) ifc.tx_empty_it = 1'b1;
    end
    if (ifc.tx_load === 1'b1) ecd = 2;
    drive();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    drive();
    ifc.tx_empty_it = 1'b0;
    tick();
    rst = 1'b0;
    ecd = 0;
    tb_credit = 1'b1;
    ifc.tx_empty_it = 1'b0;
  endtask
  task automatic wait_load(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ifc.tx_load !== 1'b1 && cnt < 100);
    chk("load_seen", {31'd0, ifc.tx_load}, 1);
  endtask
  initial begin
    cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    do_reset();
    chk("rst_ready", {28'd0, ifc.req_ready}, 0);
    chk("rst_load", {31'd0, ifc.tx_load}, 0);
    chk("rst_data", {24'd0, ifc.tx_data}, 0);
    chk("rst_active", {31'd0, grant_active}, 0);
    chk("rst_gid", {29'd0, grant_id}, 0);
    chk("rst_err", {31'd0, err_timeout}, 0);
    chk("rst_credit", {31'd0, dut.credit}, 1);
    push(0, 8'h55, 1'b1);
    drive();
    wait_load(n);
    chk("t1_latency", n, 2);
    chk("t1_byte", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd0, 8'h55});
    chk("t1_active", {31'd0, grant_active}, 0);
    chk("t1_rr_ptr", {29'd0, dut.rr_ptr}, 1);
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 8'hA0 + 8'(i), 1'b1);
    push(0, 8'hA4, 1'b1);
    drive();
    for (int k = 0; k < 5; k++) begin
      wait_load(n);
      chk("t2_rr_order", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'(k % 4), 8'hA0 + 8'(k)});
    end
    do_reset();
    for (int k = 0; k < 20; k++) push(2, 8'(k), k == 19);
    push(3, 8'hEE, 1'b1);
    drive();
    for (int k = 0; k < 16; k++) begin
      wait_load(n);
      chk("t3_burst", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd2, 8'(k)});
    end
    wait_load(n);
    chk("t3_rotate", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd3, 8'hEE});
    for (int k = 16; k < 20; k++) begin
      wait_load(n);
      chk("t3_resume", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd2, 8'(k)});
    end
    do_reset();
    push(1, 8'h31, 1'b0);
    push(1, 8'h32, 1'b0);
    push(1, 8'h33, 1'b0);
    push(3, 8'h3F, 1'b1);
    drive();
    for (int k = 0; k < 3; k++) begin
      wait_load(n);
      chk("t4_owner", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd1, 8'h31 + 8'(k)});
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (err_timeout !== 1'b1 && n < 200);
    chk("t4_timeout_cycles", n, 64);
    chk("t4_released", {31'd0, grant_active}, 0);
    tick();
    chk("t4_err_pulse", {31'd0, err_timeout}, 0);
    chk("t4_regrant", {31'd0, grant_active}, 1);
    wait_load(n);
    chk("t4_next_owner", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd3, 8'h3F});
    do_reset();
    push(0, 8'h51, 1'b0);
    push(0, 8'h52, 1'b0);
    push(0, 8'h53, 1'b1);
    drive();
    wait_load(n);
    chk("t5_first", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd0, 8'h51});
    n = 0;
    while (ifc.req_ready[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t5_ready_seen", {31'd0, ifc.req_ready[0]}, 1);
    cfg_enable = 1'b0;
    #1;
    chk("t5_ready_drop", {28'd0, ifc.req_ready}, 0);
    tick();
    chk("t5_active_drop", {31'd0, grant_active}, 0);
    chk("t5_no_load", {31'd0, ifc.tx_load}, 0);
    for (int k = 0; k < 5; k++) tick();
    chk("t5_still_idle", {31'd0, grant_active}, 0);
    chk("t5_rr_kept", {29'd0, dut.rr_ptr}, 0);
    chk("t5_credit_kept", {31'd0, dut.credit}, 1);
    push(1, 8'h61, 1'b1);
    drive();
    cfg_enable = 1'b1;
    wait_load(n);
    chk("t5_reen_latency", n, 2);
    chk("t5_reen_byte", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd0, 8'h52});
    wait_load(n);
    chk("t5_tail", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd0, 8'h53});
    wait_load(n);
    chk("t5_next", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd1, 8'h61});
    do_reset();
    push(0, 8'h71, 1'b0);
    push(0, 8'h72, 1'b1);
    drive();
    wait_load(n);
    chk("t6_first", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd0, 8'h71});
    do_reset();
    chk("t6_load", {31'd0, ifc.tx_load}, 0);
    chk("t6_data", {24'd0, ifc.tx_data}, 0);
    chk("t6_active", {31'd0, grant_active}, 0);
    chk("t6_ready", {28'd0, ifc.req_ready}, 0);
    chk("t6_credit", {31'd0, dut.credit}, 1);
    ifc.tx_empty_it = 1'b1;
    tick();
    tick();
    chk("t6_spurious_credit", {31'd0, dut.credit}, 1);
    chk("t6_spurious_load", {31'd0, ifc.tx_load}, 0);
    push(2, 8'h99, 1'b1);
    drive();
    wait_load(n);
    chk("t6_after_latency", n, 2);
    chk("t6_after_byte", {21'd0, grant_id, ifc.tx_data}, {21'd0, 3'd2, 8'h99});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter among NREQ byte-stream requesters.
- Each requester streams bytes with valid/ready/last. A grant is held for a whole packet (through `last`), or until a burst or idle limit forces rotation.
- Feeds the transmitter one byte at a time, using the transmitter's empty interrupt as a one-deep credit.
- Sits between the host-side producers (register block, DMA, debug) and the UART tx datapath, alongside clock gen and rx.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 16, max bytes per grant before forced rotation (1..255).
- IDLE_TO, 64, cycles the owner may hold the grant with req_valid low before forced release (1..1023).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_enable  in  1  scheduler enable.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NREQ  byte is last of packet.
- req_ready  out  NREQ  per-requester accept; combinational from registered state.
- tx_data  out  8  byte to transmitter.
- tx_load  out  1  one-cycle strobe: tx_data valid for transmitter.
- tx_empty_it  in  1  one-cycle pulse: transmitter has taken the byte and can accept the next.
- grant_active  out  1  a requester owns the transmitter.
- grant_id  out  3  current or last owner index.
- err_timeout  out  1  one-cycle pulse on idle-timeout release.

Behaviour:
- Reset values:
  - Outputs: req_ready=0, tx_load=0, tx_data=0, grant_active=0, grant_id=0, err_timeout=0.
  - Internal: rr_ptr=0, credit=1, burst_cnt=0, idle_cnt=0, state=IDLE.
- Reset mid-operation: all of the above restored at the next edge. A partially sent packet is abandoned; no tx_load is issued from pending state.
- credit:
  - Set by tx_empty_it.
  - Cleared on the cycle a handshake fires.
  - tx_empty_it while credit=1 is ignored.
- IDLE:
  - Requires cfg_enable=1 and any req_valid=1.
  - Winner = first index with req_valid=1, searching from rr_ptr upward with wrap (NREQ-1 -> 0).
  - Next edge: grant_id<=winner, grant_active<=1, burst_cnt<=0, idle_cnt<=0, state<=GRANT.
  - Arbitration costs one cycle; req_ready is 0 in IDLE.
- GRANT:
  - req_ready[grant_id] = cfg_enable & credit. All other req_ready bits are 0.
  - Handshake fires when req_valid[grant_id] & req_ready[grant_id].
  - On handshake, next edge: tx_data<=byte, tx_load<=1 (exactly 1 cycle), credit<=0, burst_cnt++, idle_cnt<=0.
  - Release after a handshake, if req_last=1 or burst_cnt+1==MAX_BURST:
    - state<=IDLE, grant_active<=0, rr_ptr<=(grant_id+1) mod NREQ.
  - No handshake and req_valid[grant_id]=0: idle_cnt++.
  - idle_cnt reaching IDLE_TO-1 with valid still low: release as above and err_timeout pulses 1 cycle.
  - No handshake and req_valid=1 but credit=0: wait; idle_cnt held.
- cfg_enable=0:
  - Next edge: state<=IDLE, grant_active<=0; rr_ptr unchanged.
  - req_ready is 0 in the same cycle (combinational).
  - An already-issued tx_load is not revoked. credit keeps tracking tx_empty_it.
- Simultaneous events:
  - Release and other requests in the same cycle: new arbitration waits until the cycle after entering IDLE, using the updated rr_ptr.
  - Timeout and late valid in the same cycle: the handshake wins; no timeout.
- Latency:
  - Valid from IDLE to first tx_load: 3 cycles (arb, handshake, load) when credit=1.
  - Back-to-back bytes: gated only by tx_empty_it.
- grant_id holds its last value while idle.
- Width rule: burst_cnt is 8 bits; idle_cnt is 10 bits.

Decomposition:
- uart_pkg:
  - UART_BYTE_W=8.
  - Scheduler state encoding IDLE=0, GRANT=1.
  - Max NREQ=8; grant id width 3.
- Sub-module uart_rr_arbiter:
  - Inputs: valid[NREQ], ptr. Outputs: any, winner index.
  - Purely combinational rotate-priority-encode.
- All counters and the FSM live in uart_tx_sched.

Test Plan:
- Reset then req_valid=4'b0001, data 0x55, last=1, tx_empty_it pulsed 2 cycles after each tx_load -> tx_load at cycle 3 with tx_data=0x55; grant_active drops; rr_ptr=1.
- All 4 requesters valid, single-byte packets (last=1) -> grants in order 0,1,2,3,0; one tx_load per tx_empty_it; never two tx_load without an intervening tx_empty_it.
- Requester 2 sends a 20-byte packet with MAX_BURST=16, requester 3 also valid -> 16 bytes from 2, then 3's packet, then bytes 17-20 from 2.
- Owner 1 sends 3 bytes without last, then drops valid -> err_timeout pulses after IDLE_TO=64 idle cycles; grant moves to the next valid requester.
- cfg_enable deasserted mid-packet -> req_ready=0 the same cycle; grant_active=0 the next edge; the in-flight byte completes; re-enable resumes arbitration from the unchanged rr_ptr.
- rst asserted one cycle after a handshake -> tx_load=0, credit=1, all outputs at reset values the next edge; spurious tx_empty_it afterwards is ignored.
